// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: iterative radix-2 Booth multiplier, WIDTH+1 steps per product, start/done handshake
// Define BOOTH_UNSIGNED_EN to honour is_signed; otherwise all operands are treated as signed.
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(E + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [E-1:0] br, ac, qr, sum;
  logic [2*E-1:0] shifted;
  logic [CW-1:0] count;
  logic qnext, sx, load, last;
`ifdef BOOTH_UNSIGNED_EN
  assign sx = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sx = 1'b1;
`endif
  assign load = start && state != RUN;
  assign last = state == RUN && count == CW'(E - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    sum = ({qr[0], qnext} == 2'b01) ? ac + br : ({qr[0], qnext} == 2'b10) ? ac - br : ac;
    shifted = {sum[E-1], sum, qr[E-1:1]};
    state_nx = load ? RUN : last ? DONE : (state == RUN) ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br <= '0;
      ac <= '0;
      qr <= '0;
      qnext <= 1'b0;
      count <= '0;
      product <= '0;
    end else if (load) begin
      br <= {sx & multiplicand[WIDTH-1], multiplicand};
      ac <= '0;
      qr <= {sx & multiplier[WIDTH-1], multiplier};
      qnext <= 1'b0;
      count <= '0;
    end else if (state == RUN) begin
      {ac, qr} <= shifted;
      qnext <= qr[0];
      count <= count + 1'b1;
      if (last) product <= shifted[2*WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: directed checks of the 8-bit multiplier plus a 16-bit instance against a reference product
module tb_booth_multiplier_seq;
  logic clk = 0, rst_n = 0;
  logic start = 0, sgn = 1;
  logic [7:0] a = 0, b = 0;
  logic busy, done;
  logic [15:0] product;
  logic start16 = 0, sgn16 = 1;
  logic [15:0] a16 = 0, b16 = 0;
  logic busy16, done16;
  logic [31:0] product16;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  booth_multiplier_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(sgn),
    .multiplicand(a), .multiplier(b), .busy(busy), .done(done), .product(product));
  booth_multiplier_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16),
    .multiplicand(a16), .multiplier(b16), .busy(busy16), .done(done16), .product(product16));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // accept on the next edge, then wait for done; optionally pulse start mid-run with other operands
  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s,
                      input logic [15:0] exp, input bit poke);
    int lat, nb;
    start = 1; a = x; b = y; sgn = s;
    tick();
    start = 0;
    lat = 0; nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      if (poke && lat == 3) begin start = 1; a = 8'h02; b = 8'h02; end
      else start = 0;
      tick();
      lat++;
    end
    start = 0;
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busy"}, nb, 9);
    chk({tag, "_prod"}, product, exp);
  endtask
  initial begin
    longint pa, pb;
    logic [31:0] exp16;
    int lat;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", product, 0);
    @(negedge clk); rst_n = 1; #1;
    run8("sgn3xm5", 8'd3, 8'hFB, 1, 16'hFFF1, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("hold_prod", product, 16'hFFF1);
    run8("min_min", 8'h80, 8'h80, 1, 16'h4000, 0);
`ifdef BOOTH_UNSIGNED_EN
    run8("uns_ff", 8'hFF, 8'hFF, 0, 16'hFE01, 0);
`else
    run8("uns_ff", 8'hFF, 8'hFF, 0, 16'h0001, 0);
`endif
    run8("sgn_ff", 8'hFF, 8'hFF, 1, 16'h0001, 0);
    run8("poke", 8'd7, 8'd9, 1, 16'h003F, 1);
    tick(); tick();
    chk("poke_idle", busy, 0);
    chk("poke_hold", product, 16'h003F);
    // start held high: second operands picked up on the DONE edge
    start = 1; a = 8'h7F; b = 8'h81; sgn = 1;
    tick();
    a = 8'h05; b = 8'hFF;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("held1_lat", lat, 9);
    chk("held1_prod", product, 16'hC0FF);
    lat = 0;
    tick(); lat++;
    while (!done && lat < 40) begin tick(); lat++; end
    start = 0;
    chk("held2_gap", lat, 10);
    chk("held2_prod", product, 16'hFFFB);
    tick(); tick();
    // reset abort after four steps
    start = 1; a = 8'd10; b = 8'd10;
    tick();
    start = 0;
    repeat (4) tick();
    chk("pre_abort_busy", busy, 1);
    rst_n = 0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_prod", product, 0);
    repeat (2) tick();
    @(negedge clk); rst_n = 1;
    lat = 0;
    repeat (15) begin tick(); if (done) lat++; end
    chk("abort_nodone", lat, 0);
    run8("after_rst", 8'h12, 8'h34, 1, 16'h03A8, 0);
    // 16-bit instance against a reference product
    repeat (200) begin
      a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
`ifdef BOOTH_UNSIGNED_EN
      pa = sgn16 ? longint'($signed(a16)) : longint'(a16);
      pb = sgn16 ? longint'($signed(b16)) : longint'(b16);
`else
      pa = longint'($signed(a16));
      pb = longint'($signed(b16));
`endif
      exp16 = 32'(pa * pb);
      start16 = 1;
      tick();
      start16 = 0;
      lat = 0;
      while (!done16 && lat < 40) begin tick(); lat++; end
      chk("w16_lat", lat, 17);
      chk("w16_prod", product16, exp16);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
